// File: rtl/aq_djpeg_ycbcr2rgb_out.sv
// MCU read-out and YCbCr->RGB conversion: raster-reads 256 pixels per MCU, converts, and presents them via a skid FIFO.
// Latency: address at t, pixel valid at t+4. Backpressure: address issue is credit-limited so the FIFO never overflows.

// Generic FWFT FIFO. Latency: a push is visible on dat_o the next cycle.
// Backpressure: push is dropped only if full with no simultaneous pop; the caller prevents that.
module aq_djpeg_fifo #(
  parameter int W  = 33,
  parameter int AW = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [W-1:0]  dat_i,
  input  logic          pop_i,
  output logic [W-1:0]  dat_o,
  output logic          vld_o,
  output logic [AW:0]   cnt_o
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_pop, do_push;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != (AW+1)'(DEPTH)) || do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) mem_q[wr_q] <= dat_i;
  end

  assign dat_o = mem_q[rd_q];
  assign vld_o = (cnt_q != '0);
  assign cnt_o = cnt_q;
endmodule

// Top: two-state read FSM, 3-stage colour pipeline, 8-entry output FIFO.
// Latency 4 cycles address-to-OutValid; issue stalls when FIFO count + in-flight reaches 8.
module aq_djpeg_ycbcr2rgb_out (
  input  logic       clk,
  input  logic       rst,
  input  logic       DataInit,
  input  logic [2:0] JpegComp,
  input  logic       DataOutEnable,
  output logic [7:0] DataOutAddress,
  output logic       DataOutRead,
  output logic       DataOutReadNext,
  input  logic [8:0] DataOutY,
  input  logic [8:0] DataOutCb,
  input  logic [8:0] DataOutCr,
  output logic       OutValid,
  input  logic       OutReady,
  output logic [7:0] OutR,
  output logic [7:0] OutG,
  output logic [7:0] OutB,
  output logic [7:0] OutIndex,
  output logic       OutLast
);
  typedef enum logic {S_IDLE, S_READ} state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] idx;
    logic       last;
  } pix_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       issue, read_next;

  logic              v1_q;
  logic [7:0]        idx1_q;
  logic              v2_q;
  logic signed [8:0] y2_q, cb2_q, cr2_q;
  logic [7:0]        idx2_q;
  logic               v3_q;
  logic signed [19:0] yp3_q, pr3_q, pg3_q, pb3_q;
  logic [7:0]         idx3_q;

  logic [3:0] fifo_cnt;
  logic [3:0] occ;
  logic       credit;
  logic       fifo_vld;
  pix_t       fifo_pix, push_pix;

  // Credit covers every issued address that has not yet landed in the FIFO.
  assign occ    = fifo_cnt + {3'b0, v1_q} + {3'b0, v2_q} + {3'b0, v3_q};
  assign credit = (occ < 4'd8);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    issue     = 1'b0;
    read_next = 1'b0;
    if (DataInit) begin
      state_d = S_IDLE;
      cnt_d   = 8'd0;
    end else begin
      case (state_q)
        S_IDLE: if (DataOutEnable) state_d = S_READ;
        S_READ: begin
          if (credit) begin
            issue = 1'b1;
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == 8'd255) begin
              read_next = 1'b1;
              state_d   = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign DataOutRead     = issue;
  assign DataOutReadNext = read_next;
  assign DataOutAddress  = cnt_q;

  logic               gray;
  logic signed [19:0] y_x, cb_x, cr_x;
  logic signed [19:0] yp_d, pr_d, pg_d, pb_d;

  assign gray = (JpegComp == 3'd1);
  assign y_x  = {{11{y2_q[8]}},  y2_q};
  assign cb_x = {{11{cb2_q[8]}}, cb2_q};
  assign cr_x = {{11{cr2_q[8]}}, cr2_q};

  // Rounding constant is folded into the product stage so P3 is a single add.
  assign yp_d = y_x + 20'sd128;
  assign pr_d = 20'sd359 * cr_x + 20'sd128;
  assign pg_d = 20'sd128 - 20'sd88 * cb_x - 20'sd183 * cr_x;
  assign pb_d = 20'sd454 * cb_x + 20'sd128;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      idx1_q <= 8'd0;
      v2_q   <= 1'b0;
      y2_q   <= '0;
      cb2_q  <= '0;
      cr2_q  <= '0;
      idx2_q <= 8'd0;
      v3_q   <= 1'b0;
      yp3_q  <= '0;
      pr3_q  <= '0;
      pg3_q  <= '0;
      pb3_q  <= '0;
      idx3_q <= 8'd0;
    end else begin
      v1_q   <= issue && !DataInit;
      idx1_q <= cnt_q;
      v2_q   <= v1_q && !DataInit;
      y2_q   <= DataOutY;
      cb2_q  <= gray ? 9'sd0 : DataOutCb;
      cr2_q  <= gray ? 9'sd0 : DataOutCr;
      idx2_q <= idx1_q;
      v3_q   <= v2_q && !DataInit;
      yp3_q  <= yp_d;
      pr3_q  <= pr_d;
      pg3_q  <= pg_d;
      pb3_q  <= pb_d;
      idx3_q <= idx2_q;
    end
  end

  function automatic logic [7:0] clamp8(input logic signed [19:0] v);
    if (v < 20'sd0)        return 8'd0;
    else if (v > 20'sd255) return 8'hFF;
    else                   return v[7:0];
  endfunction

  always_comb begin
    push_pix.r    = clamp8(yp3_q + (pr3_q >>> 8));
    push_pix.g    = clamp8(yp3_q + (pg3_q >>> 8));
    push_pix.b    = clamp8(yp3_q + (pb3_q >>> 8));
    push_pix.idx  = idx3_q;
    push_pix.last = (idx3_q == 8'd255);
  end

  aq_djpeg_fifo #(.W($bits(pix_t)), .AW(3)) u_fifo (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (DataInit),
    .push_i (v3_q),
    .dat_i  (push_pix),
    .pop_i  (OutReady),
    .dat_o  (fifo_pix),
    .vld_o  (fifo_vld),
    .cnt_o  (fifo_cnt)
  );

  // Fields are masked while empty so stale memory never appears on the port.
  assign OutValid = fifo_vld;
  assign OutR     = fifo_vld ? fifo_pix.r    : 8'd0;
  assign OutG     = fifo_vld ? fifo_pix.g    : 8'd0;
  assign OutB     = fifo_vld ? fifo_pix.b    : 8'd0;
  assign OutIndex = fifo_vld ? fifo_pix.idx  : 8'd0;
  assign OutLast  = fifo_vld ? fifo_pix.last : 1'b0;
endmodule
